// File: rtl/cam_insert_ctrl.sv
// Insert/delete/lookup/flush controller in front of a 32-entry CAM.
// Keeps a live bitmap so that deleted or flushed CAM entries read back as misses.
module cam_insert_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic [31:0] req_data_i,
    output logic        rsp_valid_o,
    output logic [1:0]  rsp_status_o,
    output logic [4:0]  rsp_index_o,
    output logic [5:0]  occupancy_o,
    output logic        search_enable_i,
    output logic [31:0] search_data_i,
    output logic        write_enable_i,
    output logic [4:0]  write_index_i,
    output logic [31:0] write_data_i,
    output logic        read_enable_i,
    output logic [4:0]  read_index_i,
    input  logic        search_valid_o,
    input  logic [4:0]  search_index_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEARCH,
        S_EVAL,
        S_WRITE,
        S_RESP
    } state_t;

    localparam logic [1:0] OP_INSERT = 2'b00;
    localparam logic [1:0] OP_DELETE = 2'b01;
    localparam logic [1:0] OP_FLUSH  = 2'b11;

    localparam logic [1:0] ST_OK_NEW    = 2'b00;
    localparam logic [1:0] ST_OK_HIT    = 2'b01;
    localparam logic [1:0] ST_FULL      = 2'b10;
    localparam logic [1:0] ST_NOT_FOUND = 2'b11;

    state_t      state_q, state_d;
    logic [31:0] key_q, key_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] live_q, live_d;
    logic [4:0]  alloc_q, alloc_d;
    logic [1:0]  status_q, status_d;
    logic [4:0]  index_q, index_d;

    logic        accept;
    logic        live_hit;
    logic        is_full;
    logic [4:0]  free_idx;

    assign accept   = req_valid_i && (state_q == S_IDLE);
    assign live_hit = search_valid_o && live_q[search_index_o];
    assign is_full  = &live_q;

    // Descending scan so the lowest-numbered free slot is the last one assigned.
    always_comb begin
        free_idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (!live_q[i]) begin
                free_idx = 5'(i);
            end
        end
    end

    always_comb begin
        occupancy_o = 6'd0;
        for (int i = 0; i < 32; i++) begin
            occupancy_o = occupancy_o + {5'd0, live_q[i]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal written in a combinational block gets a default at the
    // top; a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (req_op_i == OP_FLUSH) ? S_RESP : S_SEARCH;
                end
            end
            S_SEARCH: state_d = S_EVAL;
            S_EVAL: begin
                if (!live_hit && op_q == OP_INSERT && !is_full) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_WRITE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o     = 1'b0;
        search_enable_i = 1'b0;
        write_enable_i  = 1'b0;
        rsp_valid_o     = 1'b0;
        case (state_q)
            S_IDLE:   req_ready_o     = 1'b1;
            S_SEARCH: search_enable_i = 1'b1;
            S_WRITE:  write_enable_i  = 1'b1;
            S_RESP:   rsp_valid_o     = 1'b1;
            default: ;
        endcase
    end

    assign search_data_i = key_q;
    assign write_index_i = alloc_q;
    assign write_data_i  = key_q;
    assign read_enable_i = 1'b0;
    assign read_index_i  = 5'd0;
    assign rsp_status_o  = status_q;
    assign rsp_index_o   = index_q;

    always_comb begin
        key_d    = key_q;
        op_d     = op_q;
        live_d   = live_q;
        alloc_d  = alloc_q;
        status_d = status_q;
        index_d  = index_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    key_d = req_data_i;
                    op_d  = req_op_i;
                    if (req_op_i == OP_FLUSH) begin
                        live_d   = '0;
                        status_d = ST_OK_NEW;
                        index_d  = 5'd0;
                    end
                end
            end
            S_EVAL: begin
                if (live_hit) begin
                    status_d = ST_OK_HIT;
                    index_d  = search_index_o;
                    if (op_q == OP_DELETE) begin
                        live_d[search_index_o] = 1'b0;
                    end
                end else if (op_q != OP_INSERT) begin
                    status_d = ST_NOT_FOUND;
                    index_d  = 5'd0;
                end else if (is_full) begin
                    status_d = ST_FULL;
                    index_d  = 5'd0;
                end else begin
                    // A stale hit already holds this key in the CAM, so reuse its slot.
                    alloc_d = search_valid_o ? search_index_o : free_idx;
                end
            end
            S_WRITE: begin
                live_d[alloc_q] = 1'b1;
                status_d        = ST_OK_NEW;
                index_d         = alloc_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            key_q    <= '0;
            op_q     <= '0;
            live_q   <= '0;
            alloc_q  <= '0;
            status_q <= ST_OK_NEW;
            index_q  <= '0;
        end else begin
            key_q    <= key_d;
            op_q     <= op_d;
            live_q   <= live_d;
            alloc_q  <= alloc_d;
            status_q <= status_d;
            index_q  <= index_d;
        end
    end

endmodule

// File: tb/tb_cam_insert_ctrl.sv
// Directed bench for cam_insert_ctrl with a behavioural 32-entry CAM model
// that keeps stale contents after delete/flush.
module tb_cam_insert_ctrl;

    localparam logic [1:0] OP_INSERT = 2'b00;
    localparam logic [1:0] OP_DELETE = 2'b01;
    localparam logic [1:0] OP_LOOKUP = 2'b10;
    localparam logic [1:0] OP_FLUSH  = 2'b11;

    localparam logic [1:0] ST_OK_NEW    = 2'b00;
    localparam logic [1:0] ST_OK_HIT    = 2'b01;
    localparam logic [1:0] ST_FULL      = 2'b10;
    localparam logic [1:0] ST_NOT_FOUND = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_data = '0;
    logic        rsp_valid;
    logic [1:0]  rsp_status;
    logic [4:0]  rsp_index;
    logic [5:0]  occupancy;
    logic        search_enable;
    logic [31:0] search_data;
    logic        write_enable;
    logic [4:0]  write_index;
    logic [31:0] write_data;
    logic        read_enable;
    logic [4:0]  read_index;
    logic        search_valid = 1'b0;
    logic [4:0]  search_index = '0;

    int checks = 0;
    int errors = 0;
    int overlap_cnt = 0;

    logic [31:0] cam_key [32];
    logic        cam_vld [32];

    always #5 clk = ~clk;

    cam_insert_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_op_i        (req_op),
        .req_data_i      (req_data),
        .rsp_valid_o     (rsp_valid),
        .rsp_status_o    (rsp_status),
        .rsp_index_o     (rsp_index),
        .occupancy_o     (occupancy),
        .search_enable_i (search_enable),
        .search_data_i   (search_data),
        .write_enable_i  (write_enable),
        .write_index_i   (write_index),
        .write_data_i    (write_data),
        .read_enable_i   (read_enable),
        .read_index_i    (read_index),
        .search_valid_o  (search_valid),
        .search_index_o  (search_index)
    );

    // CAM model: lowest matching entry wins; contents never cleared.
    always @(posedge clk) begin
        search_valid <= 1'b0;
        if (search_enable) begin
            for (int i = 31; i >= 0; i--) begin
                if (cam_vld[i] && cam_key[i] == search_data) begin
                    search_valid <= 1'b1;
                    search_index <= 5'(i);
                end
            end
        end
        if (write_enable) begin
            cam_key[write_index] <= write_data;
            cam_vld[write_index] <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (search_enable && write_enable) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic [1:0] op, input logic [31:0] key,
                          output int lat, output logic [1:0] st, output logic [4:0] idx,
                          output int wr_cnt, output logic [4:0] wr_idx, output int wr_cyc);
        @(negedge clk);
        check("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = key;
        @(posedge clk);
        lat = -1; st = 2'b00; idx = 5'd0;
        wr_cnt = 0; wr_idx = 5'd0; wr_cyc = 0;
        for (int c = 1; c <= 10 && lat < 0; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (write_enable) begin
                wr_cnt++;
                wr_idx = write_index;
                wr_cyc = c;
            end
            if (rsp_valid) begin
                lat = c;
                st  = rsp_status;
                idx = rsp_index;
            end
        end
    endtask

    task automatic run_chk(input string tag, input logic [1:0] op, input logic [31:0] key,
                           input int exp_lat, input logic [1:0] exp_st, input logic [4:0] exp_idx,
                           input int exp_wr, input logic [5:0] exp_occ);
        int lat, wr_cnt, wr_cyc;
        logic [1:0] st;
        logic [4:0] idx, wr_idx;
        do_req(op, key, lat, st, idx, wr_cnt, wr_idx, wr_cyc);
        check({tag, "_lat"},    32'(lat), 32'(exp_lat));
        check({tag, "_status"}, {30'd0, st}, {30'd0, exp_st});
        check({tag, "_index"},  {27'd0, idx}, {27'd0, exp_idx});
        check({tag, "_writes"}, 32'(wr_cnt), 32'(exp_wr));
        if (exp_wr != 0) begin
            check({tag, "_wr_index"}, {27'd0, wr_idx}, {27'd0, exp_idx});
            check({tag, "_wr_cycle"}, 32'(wr_cyc), 32'd3);
        end
        check({tag, "_occ"}, {26'd0, occupancy}, {26'd0, exp_occ});
    endtask

    initial begin
        int bad_cnt;
        for (int i = 0; i < 32; i++) begin
            cam_vld[i] = 1'b0;
            cam_key[i] = '0;
        end

        repeat (2) @(negedge clk);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_status",    {30'd0, rsp_status}, 32'd0);
        check("rst_index",     {27'd0, rsp_index}, 32'd0);
        check("rst_occ",       {26'd0, occupancy}, 32'd0);
        check("rst_enables",   {30'd0, search_enable, write_enable}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);

        run_chk("ins_first", OP_INSERT, 32'hDEADBEEF, 4, ST_OK_NEW, 5'd0, 1, 6'd1);
        run_chk("ins_again", OP_INSERT, 32'hDEADBEEF, 3, ST_OK_HIT, 5'd0, 0, 6'd1);
        @(negedge clk);
        check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("hold_status",    {30'd0, rsp_status}, {30'd0, ST_OK_HIT});

        for (int i = 1; i < 32; i++) begin
            run_chk($sformatf("fill_%0d", i), OP_INSERT, 32'h1000 + 32'(i),
                    4, ST_OK_NEW, 5'(i), 1, 6'(i + 1));
        end
        run_chk("ins_full", OP_INSERT, 32'h5555, 3, ST_FULL, 5'd0, 0, 6'd32);

        run_chk("del_2",       OP_DELETE, 32'h1002, 3, ST_OK_HIT,    5'd2, 0, 6'd31);
        run_chk("del_5",       OP_DELETE, 32'h1005, 3, ST_OK_HIT,    5'd5, 0, 6'd30);
        run_chk("look_del_5",  OP_LOOKUP, 32'h1005, 3, ST_NOT_FOUND, 5'd0, 0, 6'd30);
        run_chk("look_7",      OP_LOOKUP, 32'h1007, 3, ST_OK_HIT,    5'd7, 0, 6'd30);
        run_chk("del_missing", OP_DELETE, 32'h9999, 3, ST_NOT_FOUND, 5'd0, 0, 6'd30);
        run_chk("reins_5",     OP_INSERT, 32'h1005, 4, ST_OK_NEW,    5'd5, 1, 6'd31);
        run_chk("ins_lowfree", OP_INSERT, 32'h7777, 4, ST_OK_NEW,    5'd2, 1, 6'd32);

        run_chk("flush_full", OP_FLUSH, 32'h0, 1, ST_OK_NEW, 5'd0, 0, 6'd0);
        for (int i = 0; i < 10; i++) begin
            run_chk($sformatf("refill_%0d", i), OP_INSERT, 32'hA000 + 32'(i),
                    4, ST_OK_NEW, 5'(i), 1, 6'(i + 1));
        end
        run_chk("look_pre_flush", OP_LOOKUP, 32'hA003, 3, ST_OK_HIT, 5'd3, 0, 6'd10);
        run_chk("flush_10",       OP_FLUSH,  32'h0,    1, ST_OK_NEW, 5'd0, 0, 6'd0);
        run_chk("look_stale",     OP_LOOKUP, 32'hA003, 3, ST_NOT_FOUND, 5'd0, 0, 6'd0);

        // Reset while an insert that would write sits in SEARCH.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_INSERT;
        req_data  = 32'hBEEF0001;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_in_search", {31'd0, search_enable}, 32'd1);
        rst = 1'b1;
        bad_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (c == 3) rst = 1'b0;
            @(negedge clk);
            if (write_enable || rsp_valid) bad_cnt++;
        end
        check("abort_no_wr_rsp", 32'(bad_cnt), 32'd0);
        check("abort_occ",       {26'd0, occupancy}, 32'd0);
        check("abort_ready",     {31'd0, req_ready}, 32'd1);
        run_chk("post_abort_ins", OP_INSERT, 32'hBEEF0002, 4, ST_OK_NEW, 5'd0, 1, 6'd1);

        check("no_search_write_overlap", 32'(overlap_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_insert_ctrl.md
CAM_INSERT_CTRL -- requirements
Module: cam_insert_ctrl

Interface
REQ-001 SHALL use one clock clk_i; reset rst_i asynchronous, active-high.
REQ-002 clk_i  in  1  system clock, all state on rising edge.
REQ-003 rst_i  in  1  async active-high reset.
REQ-004 req_valid_i  in  1  client request present.
REQ-005 req_ready_o  out  1  controller can accept request.
REQ-006 req_op_i  in  2  00 INSERT, 01 DELETE, 10 LOOKUP, 11 FLUSH.
REQ-007 req_data_i  in  32  key.
REQ-008 rsp_valid_o  out  1  one-cycle response pulse; no backpressure.
REQ-009 rsp_status_o  out  2  00 OK_NEW, 01 OK_HIT, 10 FULL, 11 NOT_FOUND.
REQ-010 rsp_index_o  out  5  CAM index for the response.
REQ-011 occupancy_o  out  6  live entry count, 0..32.
REQ-012 CAM side outputs: search_enable_i 1, search_data_i 32, write_enable_i 1, write_index_i 5, write_data_i 32, read_enable_i 1 (tied 0), read_index_i 5 (tied 0).
REQ-013 CAM side inputs: search_valid_o 1 (hit flag), search_index_o 5.

Function
REQ-014 CAM contract: search_valid_o/search_index_o sampled exactly one cycle after search_enable_i high; high = hit; write takes effect at the edge ending the write_enable_i cycle.
REQ-015 Controller SHALL keep a 32-bit live bitmap; a CAM hit on a non-live index is treated as a miss ("stale hit").
REQ-016 FSM states: IDLE, SEARCH, EVAL, WRITE, RESP; one request in flight at a time.
REQ-017 req_ready_o SHALL be 1 only in IDLE; handshake = req_valid_i & req_ready_o; key and op captured at that edge.
REQ-018 IDLE->SEARCH on accept of INSERT/DELETE/LOOKUP; IDLE->RESP on accept of FLUSH.
REQ-019 SEARCH: drive search_enable_i=1, search_data_i=captured key for exactly one cycle; ->EVAL.
REQ-020 EVAL, live hit: INSERT/LOOKUP -> OK_HIT at hit index; DELETE -> OK_HIT at hit index and clear that live bit at this edge; ->RESP.
REQ-021 EVAL, miss or stale hit: LOOKUP/DELETE -> NOT_FOUND, index 0, ->RESP; INSERT with occupancy 32 -> FULL, index 0, no write, ->RESP; INSERT otherwise ->WRITE.
REQ-022 INSERT allocation index: stale hit index if stale hit, else lowest-numbered non-live index.
REQ-023 WRITE: drive write_enable_i=1, write_index_i=allocated index, write_data_i=key for one cycle; set live bit at this edge; status OK_NEW; ->RESP.
REQ-024 FLUSH: clear whole bitmap at accept edge; response OK_NEW, index 0; CAM contents untouched.
REQ-025 RESP: rsp_valid_o=1 for one cycle with registered status/index; ->IDLE; next request accepted no earlier than the following cycle.
REQ-026 Latency from accept edge T: FLUSH rsp at T+1; LOOKUP/DELETE/INSERT-hit/FULL at T+3; INSERT-new at T+4.
REQ-027 occupancy_o SHALL equal popcount of bitmap, updated the same edge as the bitmap.
REQ-028 CAM enables SHALL be 0 in every state not named above; search and write never asserted together.
REQ-029 rsp_status_o/rsp_index_o hold last values when rsp_valid_o=0.

Reset
REQ-030 On rst_i: state IDLE, bitmap 0, occupancy_o 0, rsp_valid_o 0, rsp_status_o 00, rsp_index_o 0, all CAM enables 0, req_ready_o 1 after release.
REQ-031 Reset mid-operation SHALL abort the request with no response and no further CAM write.

Verification
REQ-032 Insert 0xDEADBEEF into empty -> write at index 0 at T+3, rsp OK_NEW idx 0 at T+4, occupancy 1.
REQ-033 Re-insert 0xDEADBEEF -> no write, rsp OK_HIT idx 0 at T+3, occupancy 1.
REQ-034 Insert 32 distinct keys, then 33rd -> indices 0..31 OK_NEW, 33rd FULL idx 0, no write_enable_i, occupancy 32.
REQ-035 Delete key at idx 5, lookup it -> OK_HIT idx 5 then NOT_FOUND; insert same key -> reuses idx 5 OK_NEW; new key -> lowest free index.
REQ-036 FLUSH with occupancy 10 -> OK_NEW at T+1, occupancy 0; lookup old key -> NOT_FOUND.
REQ-037 Assert rst_i during WRITE-bound insert at SEARCH -> no write_enable_i, no rsp_valid_o, occupancy 0.
